isqrt_fsm_responder: RTL and testbench

- Responder (server) end of the isqrt request/response interface used by the formula FSMs: accepts one `x_vld`/`x` request and returns `y_vld`/`y = floor(sqrt(x))`.
- Iterative, one result bit per cycle, single shared datapath; replaces a pipelined isqrt wherever one request is outstanding at a time.
- Sits directly behind a formula FSM's `isqrt_x_vld`/`isqrt_x` outputs and drives its `isqrt_y_vld`/`isqrt_y` inputs.

---
 rtl/isqrt_fsm_responder.sv | 94 +++++++++
 tb/tb_isqrt_fsm_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_fsm_responder.sv
// isqrt_fsm_responder: iterative y = floor(sqrt(x)) responder, one request outstanding at a time.
// Define ISQRT_FSM_TWO_BITS_PER_CYCLE_EN to resolve two result bits per CALC cycle.
module isqrt_fsm_responder #(
    parameter int X_W = 32,
    localparam int Y_W = X_W / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [X_W-1:0] x,
    output logic           y_vld,
    output logic [Y_W-1:0] y,
    output logic           busy,
    output logic           drop
);
    localparam int R_W = Y_W + 2;
    localparam int C_W = $clog2(Y_W);
`ifdef ISQRT_FSM_TWO_BITS_PER_CYCLE_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [C_W-1:0] CNT_LOAD = C_W'(Y_W / STEPS - 1);
    typedef enum logic {IDLE, CALC} state_t;
    state_t         state, state_n;
    logic [X_W-1:0] shift, shift_n;
    logic [R_W-1:0] rem, rem_n;
    logic [Y_W-1:0] root, root_n, y_n;
    logic [C_W-1:0] cnt, cnt_n;
    logic           y_vld_n, drop_n;
    logic [R_W+Y_W-1:0] s1, s2;
    // One restoring iteration; the partial remainder never exceeds 2*root, so the wide compare is exact.
    function automatic logic [R_W+Y_W-1:0] step(input logic [R_W-1:0] r, input logic [Y_W-1:0] q, input logic [1:0] b);
        logic ge;
        ge = {r, b} >= {2'b00, q, 2'b01};
        return {ge ? R_W'({r, b} - {2'b00, q, 2'b01}) : R_W'({r, b}), q[Y_W-2:0], ge};
    endfunction
    assign s1 = step(rem, root, shift[X_W-1 -: 2]);
`ifdef ISQRT_FSM_TWO_BITS_PER_CYCLE_EN
    assign s2 = step(s1[R_W+Y_W-1 -: R_W], s1[Y_W-1:0], shift[X_W-3 -: 2]);
`else
    assign s2 = s1;
`endif
    assign busy = state == CALC;
    always_comb begin
        state_n = state;
        shift_n = shift;
        rem_n   = rem;
        root_n  = root;
        cnt_n   = cnt;
        y_n     = y;
        y_vld_n = 1'b0;
        drop_n  = drop | (x_vld & busy);
        if (state == IDLE) begin
            if (x_vld) begin
                state_n = CALC;
                shift_n = x;
                rem_n   = '0;
                root_n  = '0;
                cnt_n   = CNT_LOAD;
            end
        end else begin
            shift_n         = shift << (2 * STEPS);
            {rem_n, root_n} = s2;
            cnt_n           = cnt - 1'b1;
            if (cnt == '0) begin
                state_n = IDLE;
                y_n     = s2[Y_W-1:0];
                y_vld_n = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            shift <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            y     <= '0;
            y_vld <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            rem   <= rem_n;
            root  <= root_n;
            cnt   <= cnt_n;
            y     <= y_n;
            y_vld <= y_vld_n;
            drop  <= drop_n;
        end
    end
endmodule

// File: tb/tb_isqrt_fsm_responder.sv
// tb_isqrt_fsm_responder: randomized and directed checks of isqrt_fsm_responder against an arithmetic model.
module tb_isqrt_fsm_responder;
    localparam int X_W = 32;
    localparam int Y_W = 16;
`ifdef ISQRT_FSM_TWO_BITS_PER_CYCLE_EN
    localparam int LAT = Y_W / 2 + 1;
`else
    localparam int LAT = Y_W + 1;
`endif
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           x_vld = 1'b0;
    logic [X_W-1:0] x = '0;
    logic           y_vld;
    logic [Y_W-1:0] y;
    logic           busy;
    logic           drop;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    isqrt_fsm_responder #(.X_W(X_W)) dut (
        .clk(clk), .rst(rst), .x_vld(x_vld), .x(x),
        .y_vld(y_vld), .y(y), .busy(busy), .drop(drop)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        longint unsigned r = 0;
        longint unsigned c;
        for (int b = 15; b >= 0; b--) begin
            c = r + (64'd1 << b);
            if (c * c <= 64'(v)) r = c;
        end
        return r[15:0];
    endfunction

    // Issues one request in the current cycle and waits (bounded) for its result strobe.
    task automatic send_wait(input logic [31:0] v, output logic [15:0] got, output int lat, output int busy_bad);
        x_vld = 1'b1;
        x = v;
        tick;
        x_vld = 1'b0;
        x = $urandom;
        lat = -1;
        busy_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            if (y_vld) begin
                lat = n;
                break;
            end
            if (!busy) busy_bad++;
            tick;
        end
        got = y;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick;
        tick;
        n_checks += 4;
        if (y_vld !== 1'b0) begin n_fail++; $display("FAIL reset_y_vld got=%b want=0", y_vld); end
        if (y !== 16'h0) begin n_fail++; $display("FAIL reset_y got=%h want=0000", y); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b want=0", drop); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_known;
        logic [31:0] vals [9] = '{32'd0, 32'd16, 32'd15, 32'hFFFF_FFFF, 32'h4000_0000, 32'd1, 32'd144, 32'd1000000, 32'd2};
        logic [15:0] exps [9] = '{16'd0, 16'd4, 16'd3, 16'hFFFF, 16'h8000, 16'd1, 16'd12, 16'd1000, 16'd1};
        logic [15:0] got;
        int lat, bb;
        for (int i = 0; i < 9; i++) begin
            send_wait(vals[i], got, lat, bb);
            n_checks += 6;
            if (got !== exps[i]) begin n_fail++; $display("FAIL known_y x=%h got=%h want=%h", vals[i], got, exps[i]); end
            if (lat !== LAT) begin n_fail++; $display("FAIL known_latency x=%h got=%0d want=%0d", vals[i], lat, LAT); end
            if (bb !== 0) begin n_fail++; $display("FAIL known_busy x=%h idle_cycles=%0d want=0", vals[i], bb); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL known_busy_at_result got=%b want=0", busy); end
            tick;
            if (y_vld !== 1'b0) begin n_fail++; $display("FAIL known_pulse_width y_vld=%b want=0", y_vld); end
            if (y !== exps[i]) begin n_fail++; $display("FAIL known_y_hold got=%h want=%h", y, exps[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] got;
        int lat, bb;
        send_wait(32'd1000000, got, lat, bb);
        n_checks += 2;
        if (got !== 16'd1000) begin n_fail++; $display("FAIL b2b_first_y got=%0d want=1000", got); end
        if (lat !== LAT) begin n_fail++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, LAT); end
        send_wait(32'd1000000 + 32'(got), got, lat, bb);
        n_checks += 3;
        if (got !== 16'd1000) begin n_fail++; $display("FAIL b2b_second_y got=%0d want=1000", got); end
        if (lat !== LAT) begin n_fail++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, LAT); end
        if (drop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got=%b want=0", drop); end
        tick;
    endtask

    task automatic test_drop;
        logic [15:0] got = '0;
        int lat = -1;
        int extra = 0;
        x_vld = 1'b1;
        x = 32'd144;
        tick;
        for (int n = 1; n <= 100; n++) begin
            x_vld = (n == 5);
            x = (n == 5) ? 32'd10000 : 32'd0;
            if (y_vld) begin
                lat = n;
                got = y;
                break;
            end
            tick;
        end
        x_vld = 1'b0;
        n_checks += 3;
        if (got !== 16'd12) begin n_fail++; $display("FAIL drop_y got=%0d want=12", got); end
        if (lat !== LAT) begin n_fail++; $display("FAIL drop_latency got=%0d want=%0d", lat, LAT); end
        if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_set got=%b want=1", drop); end
        for (int n = 0; n < 40; n++) begin
            tick;
            if (y_vld) extra++;
        end
        n_checks += 3;
        if (extra !== 0) begin n_fail++; $display("FAIL drop_extra_result got=%0d want=0", extra); end
        if (drop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got=%b want=1", drop); end
        if (y !== 16'd12) begin n_fail++; $display("FAIL drop_y_hold got=%0d want=12", y); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] got;
        int lat, bb;
        int extra = 0;
        x_vld = 1'b1;
        x = 32'd81;
        tick;
        x_vld = 1'b0;
        for (int n = 1; n < 8; n++) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        for (int n = 9; n <= 40; n++) begin
            if (y_vld) extra++;
            tick;
        end
        n_checks += 4;
        if (extra !== 0) begin n_fail++; $display("FAIL abort_result got=%0d want=0", extra); end
        if (y !== 16'd0) begin n_fail++; $display("FAIL abort_y got=%0d want=0", y); end
        if (drop !== 1'b0) begin n_fail++; $display("FAIL abort_drop got=%b want=0", drop); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        send_wait(32'd81, got, lat, bb);
        n_checks += 2;
        if (got !== 16'd9) begin n_fail++; $display("FAIL abort_retry_y got=%0d want=9", got); end
        if (lat !== LAT) begin n_fail++; $display("FAIL abort_retry_latency got=%0d want=%0d", lat, LAT); end
    endtask

    task automatic test_random;
        logic [31:0] v;
        logic [15:0] got;
        int lat, bb;
        int gap;
        for (int i = 0; i < 1003; i++) begin
            v = (i == 0) ? 32'd0 : (i == 1) ? 32'd1 : (i == 2) ? 32'hFFFF_FFFF :
                (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(0, 1 << 20));
            send_wait(v, got, lat, bb);
            n_checks += 2;
            if (got !== ref_sqrt(v)) begin n_fail++; $display("FAIL random_y x=%h got=%h want=%h", v, got, ref_sqrt(v)); end
            if (lat !== LAT) begin n_fail++; $display("FAIL random_latency x=%h got=%0d want=%0d", v, lat, LAT); end
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick;
        end
        n_checks += 1;
        if (drop !== 1'b0) begin n_fail++; $display("FAIL random_drop got=%b want=0", drop); end
    endtask

    initial begin
        test_reset;
        test_known;
        test_back_to_back;
        test_drop;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
